// File: rtl/cpu_boot_controller.sv
// Program loader and run sequencer for the single-cycle CPU: streams words into
// instruction memory, holds the CPU in reset, starts it and supervises the run.
module cpu_boot_controller #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int RESET_HOLD      = 5,
  parameter int WATCHDOG_CYCLES = 1024,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  cpu_start,
  input  logic                  halt_in,
  input  logic                  rerun,
  input  logic                  reload,
  output logic [ADDR_WIDTH:0]   loaded_words,
  output logic [CNT_WIDTH-1:0]  run_cycles,
  output logic                  done,
  output logic                  timeout,
  output logic                  overflow,
  output logic [2:0]            state
);

  // Load handshake: a beat transfers on a rising clock edge where load_valid and
  // load_ready are both high; load_ready is registered and only high in LOAD.

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0]        HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] WD_LIMIT  = CNT_WIDTH'(WATCHDOG_CYCLES);

  logic [2:0]            st, st_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_d;
  logic [HW-1:0]         hold_cnt, hold_cnt_d;
  logic                  load_ready_d, imem_we_d, cpu_reset_d, cpu_start_d;
  logic [ADDR_WIDTH-1:0] imem_addr_d;
  logic [DATA_WIDTH-1:0] imem_wdata_d;
  logic [ADDR_WIDTH:0]   loaded_words_d;
  logic [CNT_WIDTH-1:0]  run_cycles_d, run_inc;
  logic                  done_d, timeout_d, overflow_d;
  logic                  accept, ptr_max, hold_end, wd_hit, rerun_ok;

  assign accept   = (st == S_LOAD) && load_valid && load_ready;
  assign ptr_max  = (ptr == {ADDR_WIDTH{1'b1}});
  assign hold_end = (hold_cnt == HOLD_LAST);
  assign run_inc  = (run_cycles == {CNT_WIDTH{1'b1}}) ? run_cycles : run_cycles + 1'b1;
  assign wd_hit   = (run_inc >= WD_LIMIT);
  // An overflowed program is incomplete, so it may only be reloaded, never rerun.
  assign rerun_ok = rerun && !((st == S_FAULT) && overflow);
  assign state    = st;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st           <= S_LOAD;
      ptr          <= '0;
      hold_cnt     <= '0;
      load_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      cpu_start    <= 1'b0;
      loaded_words <= '0;
      run_cycles   <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      st           <= st_n;
      ptr          <= ptr_d;
      hold_cnt     <= hold_cnt_d;
      load_ready   <= load_ready_d;
      imem_we      <= imem_we_d;
      imem_addr    <= imem_addr_d;
      imem_wdata   <= imem_wdata_d;
      cpu_reset    <= cpu_reset_d;
      cpu_start    <= cpu_start_d;
      loaded_words <= loaded_words_d;
      run_cycles   <= run_cycles_d;
      done         <= done_d;
      timeout      <= timeout_d;
      overflow     <= overflow_d;
    end
  end

  always_comb begin
    st_n = st;
    case (st)
      S_LOAD: begin
        if (accept) begin
          if (load_last)    st_n = S_HOLD;
          else if (ptr_max) st_n = S_FAULT;
        end
      end
      S_HOLD:  if (hold_end) st_n = S_RUN;
      S_RUN: begin
        if (halt_in)     st_n = S_DONE;
        else if (wd_hit) st_n = S_FAULT;
      end
      S_DONE, S_FAULT: begin
        if (reload)        st_n = S_LOAD;
        else if (rerun_ok) st_n = S_HOLD;
      end
      default: st_n = S_LOAD;
    endcase
  end

  always_comb begin
    load_ready_d   = (st_n == S_LOAD);
    cpu_reset_d    = (st_n != S_RUN);
    cpu_start_d    = (st_n == S_RUN);
    imem_we_d      = accept;
    imem_addr_d    = accept ? ptr : imem_addr;
    imem_wdata_d   = accept ? load_data : imem_wdata;
    ptr_d          = accept ? ptr + 1'b1 : ptr;
    loaded_words_d = accept ? loaded_words + 1'b1 : loaded_words;
    hold_cnt_d     = ((st == S_HOLD) && !hold_end) ? hold_cnt + 1'b1 : '0;
    run_cycles_d   = run_cycles;
    done_d         = done;
    timeout_d      = timeout;
    overflow_d     = overflow;
    case (st)
      S_LOAD: if (accept && !load_last && ptr_max) overflow_d = 1'b1;
      S_RUN: begin
        run_cycles_d = run_inc;
        if (halt_in)     done_d    = 1'b1;
        else if (wd_hit) timeout_d = 1'b1;
      end
      S_DONE, S_FAULT: begin
        if (reload) begin
          ptr_d          = '0;
          loaded_words_d = '0;
          done_d         = 1'b0;
          timeout_d      = 1'b0;
          overflow_d     = 1'b0;
        end
      end
      default: ;
    endcase
    // Each new run starts with a clean cycle count and status.
    if ((st_n == S_HOLD) && (st != S_HOLD)) begin
      run_cycles_d = '0;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_boot_controller.sv
// Bench for cpu_boot_controller: scenario tasks drive the loader and run control;
// instruction-memory writes are checked against a queue of expected writes.
module tb_cpu_boot_controller;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int CW = 32;
  localparam int OW = 2 * AW + DW + CW + 8;
  localparam int W  = 16 + AW + DW;
  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;
  // Only cpu_reset is high in the reset image of the packed outputs.
  localparam logic [OW-1:0] RST_VEC = {{(OW-1){1'b0}}, 1'b1} << (CW + AW + 5);

  logic          clock, reset, load_valid, load_ready, load_last, imem_we;
  logic          cpu_reset, cpu_start, halt_in, rerun, reload, done, timeout, overflow;
  logic [DW-1:0] load_data, imem_wdata;
  logic [AW-1:0] imem_addr, wr_ptr;
  logic [AW:0]   loaded_words;
  logic [CW-1:0] run_cycles;
  logic [2:0]    state;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_e;
  logic [15:0]   cyc;
  int            n_cmp, n_bad;

  cpu_boot_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_HOLD(5), .WATCHDOG_CYCLES(16), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_start(cpu_start), .halt_in(halt_in),
    .rerun(rerun), .reload(reload), .loaded_words(loaded_words), .run_cycles(run_cycles),
    .done(done), .timeout(timeout), .overflow(overflow), .state(state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    cyc   = '0;
  end
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 16'd1;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: simulation still running at %0t", $time);
    $fatal(1);
  end

  function automatic logic [OW-1:0] outs();
    return {load_ready, imem_we, imem_addr, imem_wdata, cpu_reset, cpu_start,
            loaded_words, run_cycles, done, timeout, overflow};
  endfunction

  // scoreboard: every observed write must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset && imem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL imem_write_unexpected: got addr=%0d data=%h at cycle %0d, required no write", imem_addr, imem_wdata, cyc);
      end else begin
        exp_e = exp_q.pop_front();
        if ({cyc, imem_addr, imem_wdata} !== exp_e) begin
          n_bad++;
          $display("FAIL imem_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                   cyc, imem_addr, imem_wdata, exp_e[W-1 -: 16], exp_e[DW +: AW], exp_e[DW-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int w;
    w = 0;
    while (load_ready !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (load_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_ready_wait: load_ready=%b, required 1 within 20 cycles", load_ready);
    end else begin
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      exp_q.push_back({cyc + 16'd1, wr_ptr, d});
      wr_ptr = wr_ptr + 1'b1;
      @(negedge clock);
      load_valid = 1'b0;
      load_last  = 1'b0;
    end
  endtask

  task automatic pulse(input logic rr, input logic rl);
    rerun  = rr;
    reload = rl;
    @(negedge clock);
    rerun  = 1'b0;
    reload = 1'b0;
  endtask

  task automatic wait_start();
    int w;
    w = 0;
    while (cpu_start !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (cpu_start !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL start_wait: cpu_start=%b, required 1 within 20 cycles", cpu_start);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    halt_in = 1'b0; rerun = 1'b0; reload = 1'b0; wr_ptr = '0;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (outs() !== RST_VEC) begin n_bad++; $display("FAIL reset_async: got %h, required %h", outs(), RST_VEC); end
    n_cmp++; if (state !== S_LOAD) begin n_bad++; $display("FAIL reset_state: got %0d, required %0d", state, S_LOAD); end
    repeat (2) @(negedge clock);
    n_cmp++; if (outs() !== RST_VEC) begin n_bad++; $display("FAIL reset_held: got %h, required %h", outs(), RST_VEC); end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b, required 1", load_ready); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL release_cpu_reset: got %b, required 1", cpu_reset); end
  endtask

  task automatic test_load_hold();
    int k;
    send_beat(32'h0000_0020, 1'b0);
    send_beat(32'h0000_0021, 1'b0);
    send_beat(32'h0000_0022, 1'b1);
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL last_ready_drop: got %b, required 0", load_ready); end
    n_cmp++; if (loaded_words !== 3'd3) begin n_bad++; $display("FAIL loaded_words_3: got %0d, required 3", loaded_words); end
    n_cmp++; if (state !== S_HOLD) begin n_bad++; $display("FAIL hold_entry: got %0d, required %0d", state, S_HOLD); end
    k = 0;
    while (cpu_reset === 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    n_cmp++; if (k != 5) begin n_bad++; $display("FAIL hold_length: got %0d cycles, required 5", k); end
    n_cmp++; if (cpu_start !== 1'b1) begin n_bad++; $display("FAIL run_start: got %b, required 1", cpu_start); end
    n_cmp++; if (run_cycles !== 32'd0) begin n_bad++; $display("FAIL run_first_count: got %0d, required 0", run_cycles); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL load_writes_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_halt();
    int k;
    repeat (6) @(negedge clock);
    halt_in = 1'b1;
    @(negedge clock);
    halt_in = 1'b0;
    n_cmp++; if (done !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL halt_flags: got done=%b timeout=%b, required 1/0", done, timeout); end
    n_cmp++; if (run_cycles !== 32'd7) begin n_bad++; $display("FAIL halt_count: got %0d, required 7", run_cycles); end
    n_cmp++; if (cpu_start !== 1'b0 || cpu_reset !== 1'b1) begin n_bad++; $display("FAIL halt_cpu: got start=%b reset=%b, required 0/1", cpu_start, cpu_reset); end
    halt_in = 1'b1;
    @(negedge clock);
    halt_in = 1'b0;
    n_cmp++; if (state !== S_DONE || run_cycles !== 32'd7) begin n_bad++; $display("FAIL done_hold: got state=%0d count=%0d, required %0d/7", state, run_cycles, S_DONE); end
    pulse(1'b1, 1'b0);
    n_cmp++; if (state !== S_HOLD || run_cycles !== 32'd0 || done !== 1'b0) begin n_bad++; $display("FAIL rerun_hold: got state=%0d count=%0d done=%b, required %0d/0/0", state, run_cycles, done, S_HOLD); end
    k = 0;
    while (cpu_reset === 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    n_cmp++; if (k != 5 || cpu_start !== 1'b1) begin n_bad++; $display("FAIL rerun_hold_length: got %0d cycles start=%b, required 5/1", k, cpu_start); end
    pulse(1'b1, 1'b1);
    n_cmp++; if (state !== S_RUN || load_ready !== 1'b0) begin n_bad++; $display("FAIL run_ignores_ctrl: got state=%0d ready=%b, required %0d/0", state, load_ready, S_RUN); end
  endtask

  task automatic test_watchdog();
    int k;
    k = 0;
    while (state === S_RUN && k < 40) begin
      @(negedge clock);
      k++;
    end
    n_cmp++; if (state !== S_FAULT) begin n_bad++; $display("FAIL wd_state: got %0d, required %0d", state, S_FAULT); end
    n_cmp++; if (timeout !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL wd_flags: got timeout=%b done=%b, required 1/0", timeout, done); end
    n_cmp++; if (run_cycles !== 32'd16) begin n_bad++; $display("FAIL wd_count: got %0d, required 16", run_cycles); end
    n_cmp++; if (cpu_start !== 1'b0 || cpu_reset !== 1'b1) begin n_bad++; $display("FAIL wd_cpu: got start=%b reset=%b, required 0/1", cpu_start, cpu_reset); end
  endtask

  task automatic test_coincident();
    pulse(1'b1, 1'b0);
    wait_start();
    repeat (15) @(negedge clock);
    n_cmp++; if (run_cycles !== 32'd15) begin n_bad++; $display("FAIL tie_pre_count: got %0d, required 15", run_cycles); end
    halt_in = 1'b1;
    @(negedge clock);
    halt_in = 1'b0;
    n_cmp++; if (done !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL tie_flags: got done=%b timeout=%b, required 1/0", done, timeout); end
    n_cmp++; if (state !== S_DONE || run_cycles !== 32'd16) begin n_bad++; $display("FAIL tie_state: got state=%0d count=%0d, required %0d/16", state, run_cycles, S_DONE); end
  endtask

  task automatic test_reload();
    pulse(1'b1, 1'b1);
    wr_ptr = '0;
    n_cmp++; if (state !== S_LOAD || load_ready !== 1'b1) begin n_bad++; $display("FAIL reload_state: got state=%0d ready=%b, required %0d/1", state, load_ready, S_LOAD); end
    n_cmp++; if (loaded_words !== 3'd0) begin n_bad++; $display("FAIL reload_words: got %0d, required 0", loaded_words); end
    n_cmp++; if ({done, timeout, overflow} !== 3'b000) begin n_bad++; $display("FAIL reload_flags: got %b, required 000", {done, timeout, overflow}); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) send_beat(32'h0000_0100 + 32'(i), 1'b0);
    n_cmp++; if (overflow !== 1'b1 || state !== S_FAULT) begin n_bad++; $display("FAIL ovf_flag: got ovf=%b state=%0d, required 1/%0d", overflow, state, S_FAULT); end
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clock);
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready: got %b, required 0", load_ready); end
    load_valid = 1'b0;
    n_cmp++; if (loaded_words !== 3'd4) begin n_bad++; $display("FAIL ovf_words: got %0d, required 4", loaded_words); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL ovf_writes_pending: got %0d, required 0", exp_q.size()); end
    pulse(1'b1, 1'b0);
    n_cmp++; if (state !== S_FAULT || cpu_reset !== 1'b1) begin n_bad++; $display("FAIL ovf_rerun_ignored: got state=%0d cpu_reset=%b, required %0d/1", state, cpu_reset, S_FAULT); end
    pulse(1'b0, 1'b1);
    wr_ptr = '0;
    n_cmp++; if (state !== S_LOAD || overflow !== 1'b0 || load_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_recover: got state=%0d ovf=%b ready=%b, required %0d/0/1", state, overflow, load_ready, S_LOAD); end
  endtask

  task automatic test_reset_mid_run();
    send_beat(32'h0000_0055, 1'b1);
    wait_start();
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (outs() !== RST_VEC || state !== S_LOAD) begin n_bad++; $display("FAIL reset_mid_run: got %h state=%0d, required %h/%0d", outs(), state, RST_VEC, S_LOAD); end
    exp_q.delete();
    wr_ptr = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_load();
    send_beat(32'h0000_0071, 1'b0);
    repeat (2) @(negedge clock);
    send_beat(32'h0000_0072, 1'b0);
    @(negedge clock);
    n_cmp++; if (loaded_words !== 3'd2 || exp_q.size() != 0) begin n_bad++; $display("FAIL gap_load: got words=%0d pending=%0d, required 2/0", loaded_words, exp_q.size()); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (outs() !== RST_VEC || state !== S_LOAD) begin n_bad++; $display("FAIL reset_mid_load: got %h state=%0d, required %h/%0d", outs(), state, RST_VEC, S_LOAD); end
    exp_q.delete();
    wr_ptr = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    send_beat(32'h0000_0091, 1'b0);
    send_beat(32'h0000_0092, 1'b1);
    n_cmp++; if (loaded_words !== 3'd2 || state !== S_HOLD) begin n_bad++; $display("FAIL b2b_load: got words=%0d state=%0d, required 2/%0d", loaded_words, state, S_HOLD); end
    @(negedge clock);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_writes_pending: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_load_hold();
    test_halt();
    test_watchdog();
    test_coincident();
    test_reload();
    test_overflow();
    test_reset_mid_run();
    test_reset_mid_load();
    test_back_to_back();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_boot_controller.md
Name: cpu_boot_controller

Overview:
- Parametrised program loader and run sequencer for the single-cycle CPU.
- Streams program words into instruction memory over a valid/ready interface, holds the CPU in reset for a programmable time, then asserts start.
- Counts run cycles and ends the run on CPU halt or watchdog expiry.
- Sits between the host/bench stimulus port and the CPU's clock/reset/start and instruction-memory write port.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 10, instruction memory word-address width (depth 2**ADDR_WIDTH)
RESET_HOLD, 5, cycles cpu_reset stays asserted after load, before start (min 1)
WATCHDOG_CYCLES, 1024, run cycles before timeout (min 1)
CNT_WIDTH, 32, width of run_cycles counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
load_valid  input  1  load_data beat valid
load_ready  output  1  controller accepts beat
load_data  input  DATA_WIDTH  instruction word
load_last  input  1  marks final program word
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_WIDTH  instruction memory word address
imem_wdata  output  DATA_WIDTH  instruction memory write data
cpu_reset  output  1  active-high reset to CPU
cpu_start  output  1  start to CPU
halt_in  input  1  CPU halt indication
rerun  input  1  pulse: rerun loaded program
reload  input  1  pulse: discard program, reload
loaded_words  output  ADDR_WIDTH+1  words written in last load
run_cycles  output  CNT_WIDTH  cycles spent in RUN
done  output  1  run ended by halt
timeout  output  1  run ended by watchdog
overflow  output  1  load exceeded memory depth

Behaviour:
- States: LOAD, HOLD, RUN, DONE, FAULT. Reset (reset=0, async) -> LOAD.
- Reset values: load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, cpu_start=0, loaded_words=0, run_cycles=0, done=0, timeout=0, overflow=0. All outputs are registered.
- LOAD:
  - load_ready=1, cpu_reset=1.
  - Beat is accepted when load_valid && load_ready.
  - The accepted beat appears as imem_we=1 with imem_addr = write pointer and imem_wdata = load_data in the following cycle (1-cycle latency). The pointer then increments and loaded_words increments.
  - imem_we=0 in every cycle that follows no acceptance.
  - Accepted beat with load_last=1: write it, then go to HOLD. load_ready drops the cycle after the last beat is accepted.
  - Accepted beat at pointer 2**ADDR_WIDTH-1 with load_last=0: write it, set overflow=1, go to FAULT.
  - load_last at the final address is legal and goes to HOLD.
- HOLD:
  - cpu_reset=1, cpu_start=0, load_ready=0.
  - Hold counter runs RESET_HOLD cycles, then go to RUN.
  - run_cycles, done and timeout are cleared on entry.
- RUN:
  - cpu_reset=0, cpu_start=1.
  - run_cycles increments by 1 every RUN cycle and saturates at its maximum.
  - halt_in=1 -> DONE, done=1.
  - Else run_cycles reaching WATCHDOG_CYCLES -> FAULT, timeout=1.
  - halt_in in the same cycle as watchdog expiry: halt wins (done=1, timeout=0).
- DONE / FAULT:
  - cpu_start=0, cpu_reset=1. run_cycles, loaded_words and flags hold.
  - rerun -> HOLD. rerun from FAULT is ignored when overflow=1.
  - reload -> LOAD with pointer, loaded_words and all flags cleared.
  - rerun and reload in the same cycle: reload wins.
- rerun and reload are ignored in LOAD, HOLD and RUN.
- halt_in is ignored outside RUN.
- Asynchronous reset mid-load or mid-run: immediately return to reset values. The program is discarded logically; memory contents are not touched.

Test Plan:
- Load 3 words (0x00000020, 0x00000021, 0x00000022; last on 3rd) with continuous valid -> imem_we pulses at addr 0,1,2 one cycle after each accept; loaded_words=3; cpu_reset falls exactly RESET_HOLD=5 cycles after HOLD entry; cpu_start=1.
- Assert halt_in 7 cycles into RUN -> done=1, run_cycles=7, cpu_start=0 next cycle; rerun -> HOLD then RUN, run_cycles restarts from 0.
- Never assert halt_in, WATCHDOG_CYCLES=16 -> timeout=1, run_cycles=16, state FAULT; reload -> load_ready=1, loaded_words=0, flags 0.
- ADDR_WIDTH=2, send 5 words without last -> 4 writes (addr 0..3), overflow=1, load_ready=0, 5th beat not accepted; rerun ignored; reload recovers.
- halt_in coincident with watchdog expiry -> done=1, timeout=0.
- Drop reset low mid-RUN and mid-LOAD (between beats, with gaps in load_valid) -> all outputs to reset values asynchronously, without waiting for a clock edge; after release, reload of 2 words writes addr 0,1.
